// File: rtl/microcode_sequencer_if.sv
// Bus bundle for microcode_sequencer: run gate, live opcode/flags, microcode loader port and outputs.
// The step_req signal exists only when MICROSEQ_SINGLE_STEP_EN is defined.
interface microcode_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CW_W     = 12,
  parameter int FLAG_W   = 2
);
  localparam int FSW = $clog2(FLAG_W);

  logic                         run;
  logic [OPCODE_W-1:0]          opcode;
  logic [FLAG_W-1:0]            flags;
  logic                         ucode_we;
  logic [OPCODE_W+STEP_W-1:0]   ucode_addr;
  logic [CW_W+3+FSW-1:0]        ucode_wdata;
`ifdef MICROSEQ_SINGLE_STEP_EN
  logic                         step_req;
`endif
  logic [CW_W-1:0]              out;
  logic [STEP_W-1:0]            step_out;
  logic                         halted;
  logic [1:0]                   dbg_state;

  // Control-side inputs are sampled on the rising edge; outputs are combinational or registered.
`ifdef MICROSEQ_SINGLE_STEP_EN
  modport master (output run, opcode, flags, ucode_we, ucode_addr, ucode_wdata, step_req,
                  input out, step_out, halted, dbg_state);
  modport slave  (input run, opcode, flags, ucode_we, ucode_addr, ucode_wdata, step_req,
                  output out, step_out, halted, dbg_state);
`else
  modport master (output run, opcode, flags, ucode_we, ucode_addr, ucode_wdata,
                  input out, step_out, halted, dbg_state);
  modport slave  (input run, opcode, flags, ucode_we, ucode_addr, ucode_wdata,
                  output out, step_out, halted, dbg_state);
`endif
endinterface

// File: rtl/microcode_sequencer.sv
// Writable-store microcode sequencer with variable-length instructions, flag-conditional steps and halt latch.
// Optional MICROSEQ_SINGLE_STEP_EN gates every advance on bus.step_req.
module microcode_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CW_W     = 12,
  parameter int FLAG_W   = 2,
  parameter int HLT_BIT  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  microcode_sequencer_if.slave bus
);
  localparam int FSW    = $clog2(FLAG_W);
  localparam int ADDR_W = OPCODE_W + STEP_W;
  localparam int WORD_W = CW_W + 3 + FSW;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [STEP_W-1:0] r_step;
  logic              r_halted;

  logic [WORD_W-1:0] w_word;
  logic [CW_W-1:0]   w_ctrl;
  logic              w_last;
  logic              w_cond;
  logic              w_cond_inv;
  logic [FSW-1:0]    w_cond_sel;
  logic              w_squash;
  logic              w_step_req;
  logic              w_advance;
  logic              w_halt_set;
  logic [CW_W-1:0]   w_out;

  assign w_word     = r_mem[{bus.opcode, r_step}];
  assign w_ctrl     = w_word[CW_W-1:0];
  assign w_last     = w_word[CW_W];
  assign w_cond     = w_word[CW_W+1];
  assign w_cond_inv = w_word[CW_W+2];
  assign w_cond_sel = w_word[CW_W+3 +: FSW];
  assign w_squash   = w_cond && ((bus.flags[w_cond_sel] ^ w_cond_inv) == 1'b0);

`ifdef MICROSEQ_SINGLE_STEP_EN
  assign w_step_req = bus.step_req;
`else
  assign w_step_req = 1'b1;
`endif

  assign w_advance  = bus.run && !r_halted && w_step_req;

  always_comb begin
    w_out = '0;
    if (r_halted) begin
      w_out[HLT_BIT] = 1'b1;
    end else if (bus.run && !w_squash) begin
      w_out = w_ctrl;
    end
  end

  // A halting step latches before 'last' can reset the step, so the halt word stays addressed.
  assign w_halt_set = w_advance && w_out[HLT_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted && !bus.run) begin
      r_step   <= '0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end else if (w_advance) begin
      r_step   <= w_last ? '0 : r_step + 1'b1;
    end
  end

  // The store has no reset: loader writes must land even while rst is held.
  always_ff @(posedge clk) begin
    if (bus.ucode_we) begin
      r_mem[bus.ucode_addr] <= bus.ucode_wdata;
    end
  end

  always_comb begin
    bus.dbg_state = ST_IDLE;
    if (r_halted) begin
      bus.dbg_state = ST_HALT;
    end else if (bus.run) begin
      bus.dbg_state = ST_RUN;
    end
  end

  assign bus.out      = w_out;
  assign bus.step_out = r_step;
  assign bus.halted   = r_halted;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed test-plan scenarios plus a randomized run
// compared against an instruction-level reference model.
module tb_microcode_sequencer;
  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 3;
  localparam int CW_W     = 12;
  localparam int FLAG_W   = 2;
  localparam int HLT_BIT  = 11;
  localparam int WW       = CW_W + 3 + 1;
  localparam int DEPTH    = 128;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [WW-1:0]   m_mem [DEPTH];
  int              m_step;
  logic            m_halted;
  logic [CW_W-1:0] exp_q [$];

  microcode_sequencer_if #(.OPCODE_W(OPCODE_W), .STEP_W(STEP_W), .CW_W(CW_W), .FLAG_W(FLAG_W)) bus ();

  microcode_sequencer #(
    .OPCODE_W(OPCODE_W), .STEP_W(STEP_W), .CW_W(CW_W), .FLAG_W(FLAG_W), .HLT_BIT(HLT_BIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] mk(input logic [11:0] c, input logic l, input logic cd,
                                       input logic inv, input logic sel);
    return {sel, inv, cd, l, c};
  endfunction

  task automatic write_word(input logic [6:0] addr, input logic [WW-1:0] data);
    bus.ucode_we    = 1'b1;
    bus.ucode_addr  = addr;
    bus.ucode_wdata = data;
    m_mem[addr]     = data;
    tick();
    bus.ucode_we    = 1'b0;
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [11:0] c;
    c = 12'($urandom_range(0, 2047));
    if ($urandom_range(0, 15) == 0) c[11] = 1'b1;
    return mk(c, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b0; bus.ucode_we = 1'b0; bus.opcode = '0; bus.flags = '0;
    bus.ucode_addr = '0; bus.ucode_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.out !== 12'h000) begin n_fail++; $display("FAIL reset_out got %h want 000", bus.out); end
    n_tests++; if (bus.step_out !== 3'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", bus.step_out); end
    n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted); end
  endtask

  task automatic test_var_length();
    logic [11:0] eo [4];
    logic [2:0]  es [4];
    eo = '{12'h0C0, 12'h410, 12'h030, 12'h0C0};
    es = '{3'd0, 3'd1, 3'd2, 3'd0};
    write_word({4'd1, 3'd0}, mk(12'h0C0, 0, 0, 0, 0));
    write_word({4'd1, 3'd1}, mk(12'h410, 0, 0, 0, 0));
    write_word({4'd1, 3'd2}, mk(12'h030, 1, 0, 0, 0));
    bus.opcode = 4'd1; bus.flags = 2'b00; bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (bus.out !== eo[i]) begin n_fail++; $display("FAIL varlen_out[%0d] got %h want %h", i, bus.out, eo[i]); end
      n_tests++; if (bus.step_out !== es[i]) begin n_fail++; $display("FAIL varlen_step[%0d] got %0d want %0d", i, bus.step_out, es[i]); end
      tick();
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_conditional();
    for (int inv = 0; inv < 2; inv++) begin
      write_word({4'd7, 3'd0}, mk(12'h001, 0, 0, 0, 0));
      write_word({4'd7, 3'd1}, mk(12'h002, 0, 0, 0, 0));
      write_word({4'd7, 3'd2}, mk(12'h004, 1, 1, 1'(inv), 0));
      bus.opcode = 4'd7; bus.flags = 2'b00; bus.run = 1'b1;
      tick(); tick();
      n_tests++; if (bus.step_out !== 3'd2) begin n_fail++; $display("FAIL cond_step inv=%0d got %0d want 2", inv, bus.step_out); end
      #1;
      n_tests++; if (bus.out !== (inv ? 12'h004 : 12'h000)) begin n_fail++; $display("FAIL cond_f00 inv=%0d got %h", inv, bus.out); end
      bus.flags = 2'b01;
      #1;
      n_tests++; if (bus.out !== (inv ? 12'h000 : 12'h004)) begin n_fail++; $display("FAIL cond_f01 inv=%0d got %h", inv, bus.out); end
      tick();
      n_tests++; if (bus.step_out !== 3'd0) begin n_fail++; $display("FAIL cond_last inv=%0d got %0d want 0", inv, bus.step_out); end
      bus.run = 1'b0; bus.flags = 2'b00;
      tick();
    end
  endtask

  task automatic test_halt();
    write_word({4'hF, 3'd0}, mk(12'h001, 0, 0, 0, 0));
    write_word({4'hF, 3'd1}, mk(12'h002, 0, 0, 0, 0));
    write_word({4'hF, 3'd2}, mk(12'h800, 0, 0, 0, 0));
    bus.opcode = 4'hF; bus.run = 1'b1;
    tick(); tick();
    n_tests++; if (bus.out !== 12'h800 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_pre out=%h halted=%b want 800/0", bus.out, bus.halted); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (bus.out !== 12'h800 || bus.step_out !== 3'd2 || bus.halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold[%0d] out=%h step=%0d halted=%b want 800/2/1", i, bus.out, bus.step_out, bus.halted);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0; bus.run = 1'b0;
    #1;
    n_tests++; if (bus.halted !== 1'b0 || bus.step_out !== 3'd0) begin n_fail++; $display("FAIL halt_rst halted=%b step=%0d want 0/0", bus.halted, bus.step_out); end
  endtask

  task automatic test_wrap_run_drop();
    for (int s = 0; s < 8; s++) write_word({4'd2, 3'(s)}, mk(12'h001, 0, 0, 0, 0));
    bus.opcode = 4'd2; bus.run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_tests++; if (bus.step_out !== 3'(i % 8) || bus.out !== 12'h001) begin n_fail++; $display("FAIL wrap[%0d] step=%0d out=%h", i, bus.step_out, bus.out); end
      tick();
    end
    tick(); tick(); tick();
    n_tests++; if (bus.step_out !== 3'd4) begin n_fail++; $display("FAIL drop_at got %0d want 4", bus.step_out); end
    bus.run = 1'b0;
    #1;
    n_tests++; if (bus.out !== 12'h000) begin n_fail++; $display("FAIL drop_out got %h want 000", bus.out); end
    tick();
    n_tests++; if (bus.step_out !== 3'd0) begin n_fail++; $display("FAIL drop_step got %0d want 0", bus.step_out); end
    bus.run = 1'b1;
    #1;
    n_tests++; if (bus.out !== 12'h001) begin n_fail++; $display("FAIL restart_out got %h want 001", bus.out); end
    bus.run = 1'b0;
    tick();
  endtask

`ifdef MICROSEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int exp_step;
    exp_step = 0;
    bus.opcode = 4'd2; bus.run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.step_req = (c % 3 == 2);
      #1;
      n_tests++; if (bus.step_out !== 3'(exp_step) || bus.out !== 12'h001) begin n_fail++; $display("FAIL sstep[%0d] step=%0d out=%h want %0d/001", c, bus.step_out, bus.out, exp_step); end
      tick();
      if (c % 3 == 2) exp_step = (exp_step + 1) % 8;
    end
    bus.step_req = 1'b1; bus.run = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [WW-1:0]   w;
    logic [CW_W-1:0] e;
    logic            sq;
    logic            adv;
    for (int a = 0; a < DEPTH; a++) write_word(7'(a), rnd_word());
    rst = 1'b1; tick(); rst = 1'b0;
    m_step = 0; m_halted = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 39) == 0);
      bus.run         = ($urandom_range(0, 9) != 0);
      bus.opcode      = 4'($urandom_range(0, 15));
      bus.flags       = 2'($urandom_range(0, 3));
      bus.ucode_we    = ($urandom_range(0, 7) == 0);
      bus.ucode_addr  = 7'($urandom_range(0, DEPTH - 1));
      bus.ucode_wdata = rnd_word();
`ifdef MICROSEQ_SINGLE_STEP_EN
      bus.step_req    = 1'($urandom_range(0, 1));
`endif
      #1;
      w  = m_mem[{bus.opcode, 3'(m_step)}];
      sq = w[CW_W+1] && ((bus.flags[w[CW_W+3]] ^ w[CW_W+2]) == 1'b0);
      if (m_halted)      e = 12'h800;
      else if (!bus.run) e = 12'h000;
      else if (sq)       e = 12'h000;
      else               e = w[CW_W-1:0];
      exp_q.push_back(e);
      n_tests++; if (bus.out !== exp_q[0]) begin n_fail++; $display("FAIL rnd_out[%0d] got %h want %h", i, bus.out, exp_q[0]); end
      void'(exp_q.pop_front());
      n_tests++; if (bus.step_out !== 3'(m_step)) begin n_fail++; $display("FAIL rnd_step[%0d] got %0d want %0d", i, bus.step_out, m_step); end
      n_tests++; if (bus.halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted[%0d] got %b want %b", i, bus.halted, m_halted); end
      adv = bus.run && !m_halted;
`ifdef MICROSEQ_SINGLE_STEP_EN
      adv = adv && bus.step_req;
`endif
      if (rst) begin
        m_step = 0; m_halted = 1'b0;
      end else if (!m_halted && !bus.run) begin
        m_step = 0;
      end else if (adv) begin
        if (e[HLT_BIT])     m_halted = 1'b1;
        else if (w[CW_W])   m_step = 0;
        else                m_step = (m_step + 1) % 8;
      end
      if (bus.ucode_we) m_mem[bus.ucode_addr] = bus.ucode_wdata;
      tick();
    end
    rst = 1'b0; bus.run = 1'b0; bus.ucode_we = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
`ifdef MICROSEQ_SINGLE_STEP_EN
    bus.step_req = 1'b1;
`endif
    test_reset();
    test_var_length();
    test_conditional();
    test_halt();
    test_wrap_run_drop();
`ifdef MICROSEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
